// File: rtl/cog_hub_port_pkg.sv
// Shared encodings for the cog hub access port: size codes, sys function codes, FSM states.
package cog_hub_port_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;
  localparam logic [1:0] SZ_SYS  = 2'b11;

  localparam logic [2:0] CLKSET  = 3'd0;
  localparam logic [2:0] COGID   = 3'd1;
  localparam logic [2:0] COGINIT = 3'd2;
  localparam logic [2:0] COGSTOP = 3'd3;
  localparam logic [2:0] LOCKNEW = 3'd4;
  localparam logic [2:0] LOCKRET = 3'd5;
  localparam logic [2:0] LOCKSET = 3'd6;
  localparam logic [2:0] LOCKCLR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_CAPTURE   = 2'd3
  } state_e;

  typedef struct packed {
    logic        r;
    logic [1:0]  s;
    logic [15:0] a;
    logic [31:0] d;
  } op_t;

endpackage

// File: rtl/cog_hub_port.sv
// Per-cog hub port: holds one op until this cog's slot, drives the OR-combined bus for one
// ena_bus cycle, then waits (bounded) for the ack and returns q/c with a done pulse.
module cog_hub_port
  import cog_hub_port_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        ena_bus,
  input  logic        bus_sel_me,
  input  logic        bus_ack_me,
  input  logic [31:0] bus_q,
  input  logic        bus_c,
  input  logic        req,
  input  logic        req_r,
  input  logic [1:0]  req_s,
  input  logic [15:0] req_a,
  input  logic [31:0] req_d,
  output logic        bus_r,
  output logic        bus_e,
  output logic        bus_w,
  output logic [1:0]  bus_s,
  output logic [15:0] bus_a,
  output logic [31:0] bus_d,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic        c,
  output logic        err
);

  localparam int            CW       = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam bit            TO_EN    = (ACK_TIMEOUT != 0);

  state_e        r_state;
  op_t           r_op;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_err;
  logic [31:0]   r_q;
  logic          r_c;
  logic          w_slot;

  // The bus is wired-OR across cogs, so every field must be zero outside our own slot.
  assign w_slot = (r_state == ST_WAIT_SLOT) && bus_sel_me && ena_bus;
  assign bus_e  = w_slot;
  assign bus_r  = w_slot & r_op.r;
  assign bus_w  = w_slot & ~r_op.r;
  assign bus_s  = w_slot ? r_op.s : 2'b00;
  assign bus_a  = w_slot ? r_op.a : 16'h0000;
  assign bus_d  = w_slot ? r_op.d : 32'h0000_0000;

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;
  assign q    = r_q;
  assign c    = r_c;

  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_q     <= 32'h0000_0000;
      r_c     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_op    <= {req_r, req_s, req_a, req_d};
            r_state <= ST_WAIT_SLOT;
          end
        end
        ST_WAIT_SLOT: begin
          if (ena_bus && bus_sel_me) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Result data is only valid alongside the ack, so it is captured on entry to CAPTURE.
          if (ena_bus && bus_ack_me) begin
            r_q     <= bus_q;
            r_c     <= bus_c;
            r_done  <= 1'b1;
            r_state <= ST_CAPTURE;
          end else if (ena_bus && TO_EN) begin
            if (r_cnt == CNT_LAST) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= ST_CAPTURE;
            end else if (r_cnt != {CW{1'b1}}) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (req) begin
            r_op    <= {req_r, req_s, req_a, req_d};
            r_state <= ST_WAIT_SLOT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cog_hub_port.md
Name: cog_hub_port

Overview:
- Per-cog hub access port sitting directly upstream of the hub; one instance per cog.
- Accepts one hub operation from the cog core (rd/wr byte/word/long, or a sys op: clkset/cogid/coginit/cogstop/lock*).
- Holds the operation until this cog's rotating bus slot, then drives the shared (OR-combined) cog bus for exactly one bus-enable cycle.
- Waits for this cog's acknowledge bit, captures the returned data/carry and hands them back to the cog.

Parameters:
- ACK_TIMEOUT, 16, number of ena_bus pulses allowed in WAIT_ACK before the operation is aborted with an error; 0 disables the timeout.

Ports:
- clk_cog  in  1  cog/hub clock.
- nres  in  1  reset, synchronous, active-low.
- ena_bus  in  1  hub bus enable strobe; the hub samples the bus on clk_cog edges where this is 1.
- bus_sel_me  in  1  this cog's bit of the hub slot select; 1 means this cog owns the current bus cycle.
- bus_ack_me  in  1  this cog's bit of the hub acknowledge vector.
- bus_q  in  32  hub read data / sys result.
- bus_c  in  1  hub carry/status result.
- req  in  1  cog requests a hub operation (single-cycle pulse or level; sampled only when accepting).
- req_r  in  1  1 = read, 0 = write.
- req_s  in  2  size: 00 byte, 01 word, 10 long, 11 sys op.
- req_a  in  16  hub byte address; for sys ops [2:0] = sys function code.
- req_d  in  32  write data / sys operand.
- bus_r  out  1  to hub, gated.
- bus_e  out  1  to hub, gated.
- bus_w  out  1  to hub, gated.
- bus_s  out  2  to hub, gated.
- bus_a  out  16  to hub, gated.
- bus_d  out  32  to hub, gated.
- busy  out  1  operation in flight (any state other than IDLE).
- done  out  1  one-cycle pulse: result valid.
- q  out  32  captured result, held until the next done.
- c  out  1  captured carry, held until the next done.
- err  out  1  one-cycle pulse with done when a timeout abort occurs.

Behaviour:
- Reset (nres=0 at a clk_cog edge): state IDLE; all bus_* = 0; busy=0; done=0; err=0; q=0; c=0; timeout counter=0. Reset mid-operation drops the operation silently, with no done.
- Gating: all bus_* are 0 unless state==WAIT_SLOT && bus_sel_me && ena_bus. In that cycle:
  - bus_e=1.
  - bus_r=op_r, bus_w=!op_r, bus_s=op_s, bus_a=op_a, bus_d=op_d.
  - Outputs are combinational from the op registers and these qualifiers, because the bus is OR-combined across cogs.
- FSM:
  - IDLE: if req, latch req_r/s/a/d into op registers, go to WAIT_SLOT.
  - WAIT_SLOT: on a clk edge with ena_bus && bus_sel_me, go to WAIT_ACK and clear the counter. Otherwise stay; waiting up to 7 slot rotations is normal.
  - WAIT_ACK:
    - If ena_bus && bus_ack_me, go to CAPTURE.
    - Else if ena_bus and ACK_TIMEOUT!=0, increment the counter. When the counter reaches ACK_TIMEOUT-1 with ena_bus, go to CAPTURE with an abort flag set.
    - Counter width is clog2(ACK_TIMEOUT+1) and the counter saturates.
    - An ack that arrives without ena_bus is ignored.
  - CAPTURE (exactly 1 cycle):
    - Normal: q<=bus_q, c<=bus_c, done=1.
    - Abort: q, c unchanged; done=1, err=1.
    - Then: if req, latch the new op and go to WAIT_SLOT (back-to-back issue); else go to IDLE.
- Latency from the req edge to done: slot wait (0..7 slots) + 1 hub cycle + 2 ena_bus pulses to ack + 1 clk.
- req while in WAIT_SLOT or WAIT_ACK is ignored; no queuing. The cog must hold req until it sees !busy or done.
- Write ops still wait for the ack; q/c capture whatever the hub returns (don't-care for the cog).
- Simultaneous bus_sel_me && bus_ack_me in WAIT_SLOT: the ack is ignored (it belongs to no issued op); the slot is taken.

Decomposition:
- Shared package holds:
  - size codes: SZ_BYTE=2'b00, SZ_WORD=2'b01, SZ_LONG=2'b10, SZ_SYS=2'b11;
  - sys function codes: CLKSET=0, COGID=1, COGINIT=2, COGSTOP=3, LOCKNEW=4, LOCKRET=5, LOCKSET=6, LOCKCLR=7;
  - the FSM state encoding.
- No sub-module; a single FSM plus counter. An optional top-level wrapper instantiates 8 ports and ORs their bus_* outputs.

Test Plan:
- Long read: req_r=1, s=10, a=16'h0100; model the hub returning 32'hDEADBEEF with ack 2 ena_bus pulses after the slot -> bus_e high for exactly one cycle at the slot; done with q=32'hDEADBEEF, c=0; bus_* are 0 in all other cycles.
- Byte write while not owning the slot: req at slot offset 3, wrbyte a=16'h0003, d=8'h5A -> bus_w=1, s=00, d=32'h0000005A asserted only when bus_sel_me arrives 5 slots later; done follows the ack.
- Sys LOCKSET: s=11, a=3'b110, d=2, hub returns c=1 -> done with c=1; busy held from req to done.
- Back-to-back: req held high across CAPTURE with a new rdword -> no IDLE cycle; second bus_e at the next own slot; two done pulses.
- Timeout: ACK_TIMEOUT=4, no ack -> after 4 ena_bus pulses in WAIT_ACK, done=1 and err=1; q keeps its old value; state returns to IDLE.
- Sync reset in WAIT_ACK: nres=0 for 1 cycle, then the ack arrives -> no done, busy=0, bus_* are 0, the late ack is ignored.
